mem_access_unit: RTL

- MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
- Takes load/store requests from EX/MEM (opcode, address, store data) and runs a req/ack transaction on the external data-memory bus.
- Stalls the pipeline until the access completes, then returns the lane-aligned, sign- or zero-extended load word. That word is the dataMemrd written into the MEM/WB register.
- Byte ordering is little-endian.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
// The master issues one request and holds it until a one-cycle ack or its own timeout.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns an EX/MEM load/store into one bus
// transaction, stalls the pipeline until it completes, and returns the
// lane-aligned, sign/zero-extended load word (little-endian lanes).
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic              bus_err,
    mem_access_unit_if.master bus
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Counter value seen in the last BUSY cycle before giving up on the ack.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:                                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        logic st;
        case (op)
            OP_SB, OP_SH, OP_SW: st = 1'b1;
            default:             st = 1'b0;
        endcase
        return st;
    endfunction

    // Halfwords need an even address, words a multiple of four; bytes are always fine.
    function automatic logic op_aligned(input logic [5:0] op, input logic [1:0] lo);
        logic ok;
        case (op)
            OP_LH, OP_LHU, OP_SH: ok = (lo[0] == 1'b0);
            OP_LW, OP_SW:         ok = (lo == 2'b00);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] lo);
        logic [3:0] be;
        case (op)
            OP_SB:   be = 4'b0001 << lo;
            OP_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes so the enabled lanes carry the right bytes.
    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            OP_SB:   w = {4{d[7:0]}};
            OP_SH:   w = {2{d[15:0]}};
            OP_SW:   w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Stores (and anything unknown) return zero so rdata reads 0 after a store.
    function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lane,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h00_0000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LW:   r = d;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic [5:0]  op_r, op_nxt_s;
    logic [1:0]  lane_r, lane_nxt_s;
    logic        bus_req_r, bus_req_nxt_s;
    logic        bus_we_r, bus_we_nxt_s;
    logic [31:0] bus_addr_r, bus_addr_nxt_s;
    logic [3:0]  bus_be_r, bus_be_nxt_s;
    logic [31:0] bus_wdata_r, bus_wdata_nxt_s;
    logic [31:0] rdata_r, rdata_nxt_s;
    logic        addr_err_r, addr_err_nxt_s;
    logic        bus_err_r, bus_err_nxt_s;
    logic        stall_s;
    logic        req_s, legal_s, ack_s, timeout_s;

    assign req_s     = mem_read | mem_write;
    assign legal_s   = op_supported(opcode) & op_aligned(opcode, addr[1:0]);
    assign ack_s     = bus.bus_ack;
    assign timeout_s = (cnt_r == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: leave IDLE only for a legal request; ack or timeout ends BUSY.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && legal_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack_s || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: combinational stall plus next values of the registered outputs.
    always_comb begin
        stall_s         = 1'b0;
        cnt_nxt_s       = cnt_r;
        op_nxt_s        = op_r;
        lane_nxt_s      = lane_r;
        bus_req_nxt_s   = bus_req_r;
        bus_we_nxt_s    = bus_we_r;
        bus_addr_nxt_s  = bus_addr_r;
        bus_be_nxt_s    = bus_be_r;
        bus_wdata_nxt_s = bus_wdata_r;
        rdata_nxt_s     = rdata_r;
        addr_err_nxt_s  = 1'b0;
        bus_err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && legal_s) begin
                    stall_s         = 1'b1;
                    cnt_nxt_s       = 8'd0;
                    op_nxt_s        = opcode;
                    lane_nxt_s      = addr[1:0];
                    bus_req_nxt_s   = 1'b1;
                    bus_we_nxt_s    = op_is_store(opcode);
                    bus_addr_nxt_s  = {addr[31:2], 2'b00};
                    bus_be_nxt_s    = store_be(opcode, addr[1:0]);
                    bus_wdata_nxt_s = store_data(opcode, wdata);
                end else if (req_s) begin
                    addr_err_nxt_s  = 1'b1;
                    rdata_nxt_s     = 32'h0000_0000;
                end else begin
                    stall_s         = 1'b0;
                end
            end
            ST_BUSY: begin
                stall_s   = 1'b1;
                cnt_nxt_s = cnt_r + 8'd1;
                if (ack_s) begin
                    bus_req_nxt_s = 1'b0;
                    rdata_nxt_s   = load_extend(op_r, lane_r, bus.bus_rdata);
                end else if (timeout_s) begin
                    bus_req_nxt_s = 1'b0;
                    rdata_nxt_s   = 32'h0000_0000;
                    bus_err_nxt_s = 1'b1;
                end else begin
                    bus_req_nxt_s = 1'b1;
                end
            end
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Output and datapath registers; everything clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 8'd0;
            op_r        <= 6'd0;
            lane_r      <= 2'd0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            addr_err_r  <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            op_r        <= op_nxt_s;
            lane_r      <= lane_nxt_s;
            bus_req_r   <= bus_req_nxt_s;
            bus_we_r    <= bus_we_nxt_s;
            bus_addr_r  <= bus_addr_nxt_s;
            bus_be_r    <= bus_be_nxt_s;
            bus_wdata_r <= bus_wdata_nxt_s;
            rdata_r     <= rdata_nxt_s;
            addr_err_r  <= addr_err_nxt_s;
            bus_err_r   <= bus_err_nxt_s;
        end
    end

    assign stall         = rst ? 1'b0 : stall_s;
    assign rdata         = rdata_r;
    assign addr_err      = addr_err_r;
    assign bus_err       = bus_err_r;
    assign bus.bus_req   = bus_req_r;
    assign bus.bus_we    = bus_we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_be    = bus_be_r;
    assign bus.bus_wdata = bus_wdata_r;

endmodule
